i2c_target_regport: RTL and testbench



---
 rtl/i2c_target_regport.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_target_regport.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regport.sv
// I2C target that decodes SCL/SDA in the clk domain and exposes a byte-wide
// register port with an auto-incrementing pointer. SDA is open-drain; SCL is never stretched.
module i2c_target_regport #(
    parameter logic [6:0]  DEV_ADDR = 7'h48,
    parameter int unsigned AW       = 8,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy
);

    localparam int unsigned FCW = 4;
    localparam int unsigned BCW = 4;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
    } state_e;

    // Bit 1 = SCL, bit 0 = SDA throughout the conditioning path.
    logic [1:0]     sync0_q, sync1_q;
    logic [1:0]     filt_q, filt_p_q;
    logic [FCW-1:0] fcnt_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q   <= 2'b11;
            sync1_q   <= 2'b11;
            filt_q    <= 2'b11;
            filt_p_q  <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            sync0_q  <= {scl_in, sda_in};
            sync1_q  <= sync0_q;
            filt_p_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync1_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync1_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FCW'(1);
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_f;
    assign sda_f     = filt_q[0];
    assign scl_rise  = filt_q[1] & ~filt_p_q[1];
    assign scl_fall  = ~filt_q[1] & filt_p_q[1];
    assign start_det = filt_q[1] & filt_p_q[1] & filt_p_q[0] & ~filt_q[0];
    assign stop_det  = filt_q[1] & filt_p_q[1] & ~filt_p_q[0] & filt_q[0];

    state_e         state_q;
    logic [BCW-1:0] bcnt_q;
    logic [7:0]     shift_q;
    logic [AW-1:0]  ptr_q;
    logic           first_q, rw_q, phase_q, inc_q;
    logic           sda_oe_q, wr_en_q, busy_q;
    logic [AW-1:0]  wr_addr_q;
    logic [7:0]     wr_data_q;
    logic [7:0]     rx_byte_d;

    assign rx_byte_d = {shift_q[6:0], sda_f};

    // phase_q splits the ACK states into "before ACK drive" and "ACK being driven/seen".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            first_q   <= 1'b0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            inc_q     <= 1'b0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (inc_q) begin
                ptr_q <= ptr_q + AW'(1);
                inc_q <= 1'b0;
            end
            if (start_det) begin
                state_q  <= ADDR;
                bcnt_q   <= '0;
                sda_oe_q <= 1'b0;
            end else if (stop_det) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shift_q <= rx_byte_d;
                        bcnt_q  <= bcnt_q + BCW'(1);
                        if (bcnt_q == BCW'(7)) begin
                            if (rx_byte_d[7:1] == DEV_ADDR && DEV_ADDR != 7'h00) begin
                                state_q <= ADDR_ACK;
                                busy_q  <= 1'b1;
                                rw_q    <= rx_byte_d[0];
                                phase_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_q <= 1'b1;
                            phase_q  <= 1'b1;
                        end else if (!rw_q) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= WR_BYTE;
                            first_q  <= 1'b1;
                            bcnt_q   <= '0;
                        end else begin
                            state_q  <= RD_BYTE;
                            shift_q  <= rd_data;
                            sda_oe_q <= ~rd_data[7];
                            bcnt_q   <= BCW'(1);
                        end
                    end
                    WR_BYTE: if (scl_rise) begin
                        shift_q <= rx_byte_d;
                        bcnt_q  <= bcnt_q + BCW'(1);
                        if (bcnt_q == BCW'(7)) begin
                            state_q <= WR_ACK;
                            phase_q <= 1'b0;
                            if (first_q) begin
                                ptr_q   <= AW'(rx_byte_d);
                                first_q <= 1'b0;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= ptr_q;
                                wr_data_q <= rx_byte_d;
                                inc_q     <= 1'b1;
                            end
                        end
                    end
                    WR_ACK: if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_q <= 1'b1;
                            phase_q  <= 1'b1;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= WR_BYTE;
                            bcnt_q   <= '0;
                        end
                    end
                    RD_BYTE: if (scl_fall) begin
                        if (bcnt_q == BCW'(8)) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= RD_ACK;
                            phase_q  <= 1'b0;
                        end else begin
                            sda_oe_q <= ~shift_q[6];
                            shift_q  <= {shift_q[6:0], 1'b0};
                            bcnt_q   <= bcnt_q + BCW'(1);
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                ptr_q   <= ptr_q + AW'(1);
                                phase_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (scl_fall && phase_q) begin
                            state_q  <= RD_BYTE;
                            shift_q  <= rd_data;
                            sda_oe_q <= ~rd_data[7];
                            bcnt_q   <= BCW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sda_oe  = sda_oe_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_addr = ptr_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_regport.sv
// Bench for i2c_target_regport: bit-banged I2C controller, register-file model
// rd_data = rd_addr ^ 8'hFF, and a queue scoreboard for writes and read bytes.
module tb_i2c_target_regport;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          scl_m, sda_m, sda_bus;
    logic          sda_oe, wr_en, busy;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [7:0]    wr_data, rd_data;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] obs_rd_q[$];
    wr_t        mon_e;
    logic [7:0] mon_got, mon_exp;
    int         errors = 0;
    int         checks = 0;
    logic       oe_seen;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;
    assign rd_data = rd_addr ^ 8'hFF;

    i2c_target_regport #(.DEV_ADDR(7'h48), .AW(AW), .FILT_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: write strobes and completed read bytes.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.a));
                check("wr_data", 32'(wr_data), 32'(mon_e.d));
            end
        end
        if (obs_rd_q.size() != 0) begin
            mon_got = obs_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h expected no byte", mon_got);
            end else begin
                mon_exp = exp_rd_q.pop_front();
                check("rd_byte", 32'(mon_got), 32'(mon_exp));
            end
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        wclk(12); sda_m = 1'b1;
        wclk(12); scl_m = 1'b1;
        wclk(20); sda_m = 1'b0;
        wclk(20); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(12); sda_m = 1'b0;
        wclk(12); scl_m = 1'b1;
        wclk(20); sda_m = 1'b1;
        wclk(20);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        wclk(12); sda_m = b;
        wclk(12); scl_m = 1'b1;
        if (glitch) begin
            wclk(8); scl_m = 1'b0;
            wclk(2); scl_m = 1'b1;
            wclk(10);
        end else begin
            wclk(20);
        end
        scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wclk(12); sda_m = 1'b1;
        wclk(12); scl_m = 1'b1;
        wclk(10); b = sda_bus;
        wclk(10); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i], i == glitch_bit);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] v;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
        send_bit(nack, 1'b0);
        obs_rd_q.push_back(v);
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ack;
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; oe_seen = 1'b0;
        wclk(3); #1;
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        rst_n = 1'b1;
        wclk(10);

        // Pointer set then two sequential writes.
        exp_wr_q.push_back('{a: 8'h10, d: 8'hA5});
        exp_wr_q.push_back('{a: 8'h11, d: 8'h5A});
        i2c_start();
        write_byte(8'h90, -1, ack); check("t1_addr_ack", 32'(ack), 0);
        check("t1_busy", 32'(busy), 1);
        write_byte(8'h10, -1, ack); check("t1_ptr_ack", 32'(ack), 0);
        write_byte(8'hA5, -1, ack); check("t1_d0_ack", 32'(ack), 0);
        write_byte(8'h5A, -1, ack); check("t1_d1_ack", 32'(ack), 0);
        i2c_stop();
        check("t1_ptr", 32'(rd_addr), 32'h12);
        check("t1_busy_stop", 32'(busy), 0);

        // Write pointer, repeated START, sequential read ending in NACK.
        exp_rd_q.push_back(8'hDF);
        exp_rd_q.push_back(8'hDE);
        exp_rd_q.push_back(8'hDD);
        i2c_start();
        write_byte(8'h90, -1, ack); check("t2_addr_ack", 32'(ack), 0);
        write_byte(8'h20, -1, ack); check("t2_ptr_ack", 32'(ack), 0);
        i2c_start();
        write_byte(8'h91, -1, ack); check("t2_raddr_ack", 32'(ack), 0);
        read_byte(1'b0);
        read_byte(1'b0);
        read_byte(1'b1);
        wclk(15);
        check("t2_release_nack", 32'(sda_oe), 0);
        check("t2_busy_held", 32'(busy), 1);
        i2c_stop();
        check("t2_busy_stop", 32'(busy), 0);
        check("t2_ptr", 32'(rd_addr), 32'h22);

        // Foreign address and general call are ignored.
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h92, -1, ack); check("t3_wrong_addr_nack", 32'(ack), 1);
        write_byte(8'h33, -1, ack); check("t3_data_nack", 32'(ack), 1);
        check("t3_busy", 32'(busy), 0);
        i2c_stop();
        i2c_start();
        write_byte(8'h00, -1, ack); check("t3_gencall_nack", 32'(ack), 1);
        i2c_stop();
        check("t3_no_drive", 32'(oe_seen), 0);

        // Pointer wrap 0xFF -> 0x00.
        exp_wr_q.push_back('{a: 8'hFF, d: 8'h01});
        exp_wr_q.push_back('{a: 8'h00, d: 8'h02});
        i2c_start();
        write_byte(8'h90, -1, ack); check("t4_addr_ack", 32'(ack), 0);
        write_byte(8'hFF, -1, ack);
        write_byte(8'h01, -1, ack);
        write_byte(8'h02, -1, ack); check("t4_d1_ack", 32'(ack), 0);
        i2c_stop();
        check("t4_ptr", 32'(rd_addr), 32'h01);

        // Short SCL glitch inside a data bit must not add a bit.
        exp_wr_q.push_back('{a: 8'h30, d: 8'hC3});
        exp_wr_q.push_back('{a: 8'h31, d: 8'h3C});
        i2c_start();
        write_byte(8'h90, -1, ack);
        write_byte(8'h30, -1, ack);
        write_byte(8'hC3, 3, ack); check("t5_glitch_ack", 32'(ack), 0);
        write_byte(8'h3C, -1, ack); check("t5_after_ack", 32'(ack), 0);
        i2c_stop();
        check("t5_ptr", 32'(rd_addr), 32'h32);

        // Reset while the target pulls SDA low during a read.
        i2c_start();
        write_byte(8'h90, -1, ack);
        write_byte(8'h80, -1, ack);
        i2c_start();
        write_byte(8'h91, -1, ack); check("t6_raddr_ack", 32'(ack), 0);
        wclk(15);
        check("t6_driving_low", 32'(sda_oe), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_release", 32'(sda_oe), 0);
        check("t6_busy_rst", 32'(busy), 0);
        check("t6_ptr_rst", 32'(rd_addr), 0);
        scl_m = 1'b1; sda_m = 1'b1;
        wclk(5);
        rst_n = 1'b1;
        wclk(10);
        exp_rd_q.push_back(8'hFF);
        i2c_start();
        write_byte(8'h91, -1, ack); check("t6_post_ack", 32'(ack), 0);
        read_byte(1'b1);
        i2c_stop();

        wclk(20);
        check("wr_all_seen", 32'(exp_wr_q.size()), 0);
        check("rd_all_seen", 32'(exp_rd_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
